// File: rtl/pc_sequencer_pkg.sv
// Shared types and default parameters for the pc_sequencer fetch-address block.
package pc_pkg;

  typedef enum logic [2:0] {
    PC_HOLD,
    PC_INC,
    PC_BRANCH,
    PC_JUMP,
    PC_CALL,
    PC_RET
  } pc_sel_e;

  localparam int unsigned PC_W_DEF      = 9;
  localparam int unsigned OFF_W_DEF     = 9;
  localparam int unsigned RESET_PC_DEF  = 0;
  localparam int unsigned STEP_DEF      = 1;
  localparam int unsigned RAS_DEPTH_DEF = 4;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a push onto a full stack overwrites the oldest
// entry, and a pop from an empty stack is refused. Both cases pulse err_o.
module pc_ras
  import pc_pkg::*;
#(
  parameter int unsigned DEPTH = RAS_DEPTH_DEF,
  parameter int unsigned W     = PC_W_DEF,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [W-1:0]     push_data_i,
  output logic [W-1:0]     top_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             err_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] ptr_inc, ptr_dec;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  // ptr_q is the next slot to write; the top of stack sits one slot below it.
  assign ptr_inc = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
  assign ptr_dec = (ptr_q == '0) ? PTR_W'(DEPTH - 1) : ptr_q - PTR_W'(1);

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign err_o   = err_q;
  assign top_o   = mem_q[ptr_dec];

  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    err_d   = 1'b0;
    if (push_i) begin
      ptr_d = ptr_inc;
      if (full_o) err_d = 1'b1;
      else        count_d = count_q + CNT_W'(1);
    end else if (pop_i) begin
      if (empty_o) begin
        err_d = 1'b1;
      end else begin
        ptr_d   = ptr_dec;
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with stall, branch, jump and (when PC_RAS_EN is
// defined) call/return through a circular return-address stack.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned PC_W      = PC_W_DEF,
  parameter int unsigned OFF_W     = OFF_W_DEF,
  parameter int unsigned RESET_PC  = RESET_PC_DEF,
  parameter int unsigned STEP      = STEP_DEF,
  parameter int unsigned RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             take_branch,
  input  logic [OFF_W-1:0] offset,
  input  logic             jump,
  input  logic             call,
  input  logic             ret,
  input  logic [PC_W-1:0]  target,
  output logic [PC_W-1:0]  pc,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_err
);

  localparam logic [PC_W-1:0] RESET_V = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0] STEP_V  = PC_W'(STEP);

  pc_sel_e         sel;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] off_ext;
  logic [PC_W-1:0] ras_top;
  logic            ret_req;

  assign pc     = pc_q;
  assign pc_inc = pc_q + STEP_V;

  generate
    if (OFF_W >= PC_W) begin : g_off_trunc
      assign off_ext = offset[PC_W-1:0];
    end else begin : g_off_sext
      assign off_ext = {{(PC_W - OFF_W){offset[OFF_W-1]}}, offset};
    end
  endgenerate

`ifdef PC_RAS_EN
  logic [$clog2(RAS_DEPTH + 1)-1:0] ras_count_unused;

  assign ret_req = ret;

  pc_ras #(
    .DEPTH (RAS_DEPTH),
    .W     (PC_W)
  ) u_ras (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (sel == PC_CALL),
    .pop_i       (sel == PC_RET),
    .push_data_i (pc_inc),
    .top_o       (ras_top),
    .count_o     (ras_count_unused),
    .full_o      (ras_full),
    .empty_o     (ras_empty),
    .err_o       (ras_err)
  );
`else
  // Without a stack, ret is dropped and call degenerates into a plain jump.
  localparam int unsigned RAS_DEPTH_UNUSED = RAS_DEPTH;
  logic unused_ret;

  assign unused_ret = ret;
  assign ret_req    = 1'b0;
  assign ras_top    = '0;
  assign ras_empty  = 1'b1;
  assign ras_full   = 1'b0;
  assign ras_err    = 1'b0;
`endif

  always_comb begin
    sel = PC_INC;
    if (stall)            sel = PC_HOLD;
    else if (ret_req)     sel = PC_RET;
`ifdef PC_RAS_EN
    else if (call)        sel = PC_CALL;
`else
    else if (call)        sel = PC_JUMP;
`endif
    else if (jump)        sel = PC_JUMP;
    else if (take_branch) sel = PC_BRANCH;
  end

  always_comb begin
    pc_d = pc_inc;
    case (sel)
      PC_HOLD:          pc_d = pc_q;
      PC_INC:           pc_d = pc_inc;
      PC_BRANCH:        pc_d = pc_q + off_ext;
      PC_JUMP, PC_CALL: pc_d = target;
      // An underflowing ret falls through to the sequential address.
      PC_RET:           pc_d = ras_empty ? pc_inc : ras_top;
      default:          pc_d = pc_inc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_V;
    else        pc_q <= pc_d;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios then random requests, each cycle
// compared against a queue-based model of the PC and return stack.
module tb_pc_sequencer;

  localparam int RAS_D = 4;

  logic       clk;
  logic       rst_n;
  logic       stall;
  logic       take_branch;
  logic [8:0] offset;
  logic       jump;
  logic       call;
  logic       ret;
  logic [8:0] target;
  logic [8:0] pc;
  logic       ras_empty;
  logic       ras_full;
  logic       ras_err;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic [8:0] pc_m;
  logic [8:0] ras_m [$];
  bit         err_m;

  pc_sequencer #(
    .PC_W      (9),
    .OFF_W     (9),
    .RESET_PC  (0),
    .STEP      (1),
    .RAS_DEPTH (RAS_D)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .take_branch (take_branch),
    .offset      (offset),
    .jump        (jump),
    .call        (call),
    .ret         (ret),
    .target      (target),
    .pc          (pc),
    .ras_empty   (ras_empty),
    .ras_full    (ras_full),
    .ras_err     (ras_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit exp_empty();
`ifdef PC_RAS_EN
    return ras_m.size() == 0;
`else
    return 1'b1;
`endif
  endfunction

  function automatic bit exp_full();
`ifdef PC_RAS_EN
    return ras_m.size() == RAS_D;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk_all(input string tag);
    chk({tag, "_pc"}, 32'(pc), 32'(pc_m));
    chk({tag, "_empty"}, 32'(ras_empty), 32'(exp_empty()));
    chk({tag, "_full"}, 32'(ras_full), 32'(exp_full()));
    chk({tag, "_err"}, 32'(ras_err), 32'(err_m));
  endtask

  // Reference: one action per edge, chosen by fixed priority, sums mod 512.
  task automatic model(input bit st, input bit rt, input bit cl, input bit jp,
                       input bit br, input logic [8:0] off, input logic [8:0] tgt);
    err_m = 1'b0;
    if (st) begin
    end
`ifdef PC_RAS_EN
    else if (rt) begin
      if (ras_m.size() == 0) begin
        pc_m  = 9'((int'(pc_m) + 1) % 512);
        err_m = 1'b1;
      end else begin
        pc_m = ras_m.pop_back();
      end
    end else if (cl) begin
      ras_m.push_back(9'((int'(pc_m) + 1) % 512));
      if (ras_m.size() > RAS_D) begin
        void'(ras_m.pop_front());
        err_m = 1'b1;
      end
      pc_m = tgt;
    end
`else
    else if (cl) pc_m = tgt;
`endif
    else if (jp) pc_m = tgt;
    else if (br) pc_m = 9'((int'(pc_m) + int'($signed(off)) + 512) % 512);
    else         pc_m = 9'((int'(pc_m) + 1) % 512);
  endtask

  // Entered just after a falling edge; leaves just after the next falling edge.
  task automatic step(input string tag, input bit st, input bit rt, input bit cl,
                      input bit jp, input bit br, input logic [8:0] off,
                      input logic [8:0] tgt);
    stall = st; ret = rt; call = cl; jump = jp; take_branch = br;
    offset = off; target = tgt;
    model(st, rt, cl, jp, br, off, tgt);
    @(posedge clk);
    #1;
    chk_all(tag);
    @(negedge clk);
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 0, 0, 0, 9'd0, 9'd0);
  endtask

  task automatic reset_dut(input string tag);
    stall = 0; ret = 0; call = 0; jump = 0; take_branch = 0;
    rst_n = 1'b0;
    #1;
    pc_m = 9'd0; err_m = 1'b0; ras_m.delete();
    chk_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reset asserted between edges while a call is being requested.
  task automatic mid_reset(input string tag);
    call = 1'b1; target = 9'd77;
    model(0, 0, 1, 0, 0, 9'd0, 9'd77);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    call = 1'b0;
    pc_m = 9'd0; err_m = 1'b0; ras_m.delete();
    chk_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    stall = 0; ret = 0; call = 0; jump = 0; take_branch = 0;
    offset = '0; target = '0;
    pc_m = '0; err_m = 1'b0;
    @(negedge clk);

    reset_dut("reset");
    for (int i = 0; i < 4; i++) idle("incr");

    step("jmp3", 0, 0, 0, 1, 0, 9'd0, 9'd3);
    step("br_neg", 0, 0, 0, 0, 1, 9'h1FB, 9'd0);
    chk("br_neg_510", 32'(pc), 32'd510);
    idle("to511");
    idle("wrap0");
    chk("wrap_zero", 32'(pc), 32'd0);

    step("jmp20", 0, 0, 0, 1, 0, 9'd0, 9'd20);
    step("jmp_over_br", 0, 0, 0, 1, 1, 9'd8, 9'd100);
    step("stall_jmp", 1, 0, 0, 1, 0, 9'd0, 9'd5);
    step("ret_call_empty", 0, 1, 1, 0, 0, 9'd0, 9'd200);

    step("jmp10", 0, 0, 0, 1, 0, 9'd0, 9'd10);
    step("call50", 0, 0, 1, 0, 0, 9'd0, 9'd50);
    chk("call50_pc", 32'(pc), 32'd50);
    idle("after_call");
    step("ret11", 0, 1, 0, 0, 0, 9'd0, 9'd0);

    step("jmp1", 0, 0, 0, 1, 0, 9'd0, 9'd1);
    for (int i = 2; i <= 6; i++) step("call_chain", 0, 0, 1, 0, 0, 9'd0, 9'(i));
    step("stall_ret", 1, 1, 0, 0, 0, 9'd0, 9'd0);
    for (int i = 0; i < 5; i++) step("ret_chain", 0, 1, 0, 0, 0, 9'd0, 9'd0);

    mid_reset("mid_reset");
    idle("post_reset");

    for (int i = 0; i < 400; i++) begin
      step("rand",
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 2) == 0,
           9'($urandom_range(0, 511)),
           9'($urandom_range(0, 511)));
      if (i == 200) mid_reset("rand_mid_reset");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
